// File: rtl/rggen_apb_bridge_if.sv
// Register-bus handshake between the register block (master) and a downstream stage (slave).
// Fields: direction 1 = write; status 2'b00 = okay, 2'b10 = slave error.
interface rggen_bus_if #(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned DATA_WIDTH    = 32
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic                     request;
  logic [ADDRESS_WIDTH-1:0] address;
  logic                     direction;
  logic [DATA_WIDTH-1:0]    write_data;
  logic [STRB_W-1:0]        write_strobe;
  logic                     done;
  logic [DATA_WIDTH-1:0]    read_data;
  logic [1:0]               status;

  modport master (
    output request, address, direction, write_data, write_strobe,
    input  done, read_data, status
  );

  modport slave (
    input  request, address, direction, write_data, write_strobe,
    output done, read_data, status
  );
endinterface

// File: rtl/rggen_apb_bridge.sv
// Converts each register-bus request into one APB4 transfer, with an optional PREADY timeout.
// Response is returned as a one-cycle done pulse with read data and status.
module rggen_apb_bridge #(
  parameter int unsigned ADDRESS_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  rggen_bus_if.slave                bus_if,
  output logic                      psel,
  output logic                      penable,
  output logic [ADDRESS_WIDTH-1:0]  paddr,
  output logic [2:0]                pprot,
  output logic                      pwrite,
  output logic [DATA_WIDTH/8-1:0]   pstrb,
  output logic [DATA_WIDTH-1:0]     pwdata,
  input  logic                      pready,
  input  logic [DATA_WIDTH-1:0]     prdata,
  input  logic                      pslverr
);
  localparam int unsigned STRB_W       = DATA_WIDTH / 8;
  localparam int unsigned CNT_W        = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TIMEOUT_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  localparam logic       RGGEN_WRITE       = 1'b1;
  localparam logic [1:0] RGGEN_OKAY        = 2'b00;
  localparam logic [1:0] RGGEN_SLAVE_ERROR = 2'b10;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETUP   = 2'd1;
  localparam logic [1:0] ACCESS  = 2'd2;
  localparam logic [1:0] RESPOND = 2'd3;

  logic [1:0]               state_q,     state_d;
  logic                     psel_q,      psel_d;
  logic                     penable_q,   penable_d;
  logic [ADDRESS_WIDTH-1:0] paddr_q,     paddr_d;
  logic                     pwrite_q,    pwrite_d;
  logic [STRB_W-1:0]        pstrb_q,     pstrb_d;
  logic [DATA_WIDTH-1:0]    pwdata_q,    pwdata_d;
  logic [CNT_W-1:0]         cnt_q,       cnt_d;
  logic                     done_q,      done_d;
  logic [DATA_WIDTH-1:0]    read_data_q, read_data_d;
  logic [1:0]               status_q,    status_d;
  logic                     timeout_hit_c;

  assign timeout_hit_c = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_LAST));

  // Next-state and registered-output logic; APB and response outputs are all flop-driven.
  always_comb begin
    state_d     = state_q;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pstrb_d     = pstrb_q;
    pwdata_d    = pwdata_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    read_data_d = '0;
    status_d    = RGGEN_OKAY;

    case (state_q)
      IDLE: begin
        if (bus_if.request) begin
          paddr_d  = bus_if.address;
          pwrite_d = (bus_if.direction == RGGEN_WRITE);
          pwdata_d = bus_if.write_data;
          pstrb_d  = (bus_if.direction == RGGEN_WRITE) ? bus_if.write_strobe : '0;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready || timeout_hit_c) begin
          // pready takes priority over a timeout landing in the same cycle
          done_d      = 1'b1;
          read_data_d = (pready && !pwrite_q) ? prdata : '0;
          status_d    = (!pready || pslverr) ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;
          paddr_d     = '0;
          pwrite_d    = 1'b0;
          pstrb_d     = '0;
          pwdata_d    = '0;
          state_d     = RESPOND;
        end else begin
          psel_d    = 1'b1;
          penable_d = 1'b1;
          if (TIMEOUT_CYCLES != 0) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pstrb_q     <= '0;
      pwdata_q    <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      read_data_q <= '0;
      status_q    <= RGGEN_OKAY;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pstrb_q     <= pstrb_d;
      pwdata_q    <= pwdata_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      read_data_q <= read_data_d;
      status_q    <= status_d;
    end
  end

  assign psel             = psel_q;
  assign penable          = penable_q;
  assign paddr            = paddr_q;
  assign pprot            = 3'b000;
  assign pwrite           = pwrite_q;
  assign pstrb            = pstrb_q;
  assign pwdata           = pwdata_q;
  assign bus_if.done      = done_q;
  assign bus_if.read_data = read_data_q;
  assign bus_if.status    = status_q;
endmodule
